// File: rtl/pipelined_adder_pkg.sv
// Shared types and defaults for the pipelined adder checker.
//   chk_state_e : checker FSM state encoding
//   Def*        : default widths/latency used by the top-level parameters
//   sum_width() : width of the full-precision sum of two operands
package pipelined_adder_pkg;

  typedef enum logic [1:0] {
    CHK_IDLE = 2'd0,
    CHK_RUN  = 2'd1,
    CHK_FAIL = 2'd2
  } chk_state_e;

  localparam int unsigned DefInpDataWidth = 8;
  localparam int unsigned DefNumRegs      = 4;
  localparam int unsigned DefCntWidth     = 16;
  localparam int unsigned MaxNumRegs      = 64;

  // One extra bit keeps the carry out so the reference sum never truncates.
  function automatic int unsigned sum_width(input int unsigned data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/adder_expect_delay.sv
// Fixed-latency shift register carrying a {valid, data} pair, one stage per cycle, no stall.
// Only the valid bits are cleared by reset; data bits are don't-care while invalid.
//   clk_i   : clock
//   rst_ni  : synchronous active-low clear of the valid bits
//   valid_i : valid bit entering stage 0
//   data_i  : data entering stage 0
//   valid_o : valid bit of the last stage
//   data_o  : data of the last stage
module adder_expect_delay #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic [Depth-1:0] valid_q;
  logic [Width-1:0] data_q [Depth];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int unsigned k = 1; k < Depth; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    data_q[0] <= data_i;
    for (int unsigned k = 1; k < Depth; k++) begin
      data_q[k] <= data_q[k-1];
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign data_o  = data_q[Depth-1];

endmodule

// File: rtl/pipelined_adder_checker.sv
// Monitor for a pipelined adder: computes the reference sum of each enabled operand pair,
// delays it by the adder latency and compares it with the adder output.
//   clk, rst_n      : clock, synchronous active-low reset
//   en, inp1, inp2  : operand pair presented to the adder and its valid flag
//   outp            : adder result
//   chk_valid       : a comparison was made (registered)
//   mismatch        : that comparison failed (registered, one-cycle pulse)
//   fail            : sticky, set by the first mismatch
//   check_count     : saturating count of comparisons
//   err_count       : saturating count of mismatches
//   first_exp/got   : expected and observed values of the first mismatch
//   first_idx       : 0-based index of the first failing comparison
module pipelined_adder_checker
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned inp_data_width = DefInpDataWidth,
  parameter int unsigned num_regs       = DefNumRegs,
  parameter int unsigned cnt_width      = DefCntWidth
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [inp_data_width-1:0] inp1,
  input  logic [inp_data_width-1:0] inp2,
  input  logic [inp_data_width:0]   outp,
  output logic                      chk_valid,
  output logic                      mismatch,
  output logic                      fail,
  output logic [cnt_width-1:0]      check_count,
  output logic [cnt_width-1:0]      err_count,
  output logic [inp_data_width:0]   first_exp,
  output logic [inp_data_width:0]   first_got,
  output logic [cnt_width-1:0]      first_idx
);

  localparam int unsigned SumWidth = sum_width(inp_data_width);
  localparam logic [cnt_width-1:0] CntMax = '1;
  localparam logic [cnt_width-1:0] CntOne = cnt_width'(1);

  if (num_regs < 1 || num_regs > MaxNumRegs) begin : g_num_regs_range
    $error("num_regs must lie in 1..64");
  end

  logic [SumWidth-1:0] exp_sum;
  logic [SumWidth-1:0] dly_sum;
  logic                dly_valid;
  logic                cmp_mismatch;

  assign exp_sum = {1'b0, inp1} + {1'b0, inp2};

  adder_expect_delay #(
    .Width (SumWidth),
    .Depth (num_regs)
  ) u_delay (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (en),
    .data_i  (exp_sum),
    .valid_o (dly_valid),
    .data_o  (dly_sum)
  );

  // outp is only meaningful when a delayed operand pair arrives.
  assign cmp_mismatch = dly_valid && (outp != dly_sum);

  chk_state_e            state_q, state_d;
  logic                  chk_valid_q, mismatch_q;
  logic [cnt_width-1:0]  check_count_q, check_count_d;
  logic [cnt_width-1:0]  err_count_q, err_count_d;
  logic [SumWidth-1:0]   first_exp_q, first_exp_d;
  logic [SumWidth-1:0]   first_got_q, first_got_d;
  logic [cnt_width-1:0]  first_idx_q, first_idx_d;

  always_comb begin
    state_d     = state_q;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;
    first_idx_d = first_idx_q;
    unique case (state_q)
      CHK_IDLE: begin
        if (en) state_d = CHK_RUN;
      end
      CHK_RUN: begin
        if (cmp_mismatch) begin
          state_d     = CHK_FAIL;
          first_exp_d = dly_sum;
          first_got_d = outp;
          first_idx_d = check_count_q;
        end
      end
      CHK_FAIL: ;
      default: state_d = CHK_IDLE;
    endcase
  end

  // Both counters stick at all-ones; err_count only moves with check_count, so it cannot pass it.
  always_comb begin
    check_count_d = check_count_q;
    err_count_d   = err_count_q;
    if (dly_valid && check_count_q != CntMax) check_count_d = check_count_q + CntOne;
    if (cmp_mismatch && err_count_q != CntMax) err_count_d = err_count_q + CntOne;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= CHK_IDLE;
      chk_valid_q   <= 1'b0;
      mismatch_q    <= 1'b0;
      check_count_q <= '0;
      err_count_q   <= '0;
      first_exp_q   <= '0;
      first_got_q   <= '0;
      first_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      chk_valid_q   <= dly_valid;
      mismatch_q    <= cmp_mismatch;
      check_count_q <= check_count_d;
      err_count_q   <= err_count_d;
      first_exp_q   <= first_exp_d;
      first_got_q   <= first_got_d;
      first_idx_q   <= first_idx_d;
    end
  end

  assign chk_valid   = chk_valid_q;
  assign mismatch    = mismatch_q;
  assign fail        = (state_q == CHK_FAIL);
  assign check_count = check_count_q;
  assign err_count   = err_count_q;
  assign first_exp   = first_exp_q;
  assign first_got   = first_got_q;
  assign first_idx   = first_idx_q;

endmodule

// File: doc/pipelined_adder_checker.md
# pipelined_adder_checker

Self-checking monitor that sits at the output end of the pipelined adder. It captures the operand pair presented to the adder each cycle and computes the reference sum. It delays that sum by the adder's pipeline depth, then compares it against the adder output. Mismatches, check counts and the first failing transaction are reported to the testbench, so regressions no longer rely on reading display logs.

## Interface
- `inp_data_width`, default 8: operand width; the sum is `inp_data_width+1` bits.
- `num_regs`, default 4: adder latency in cycles; legal range 1..64 (elaboration error outside it).
- `cnt_width`, default 16: width of the check and error counters.

Ports:
- `clk`: in, 1 bit. Single clock; all state updates on its rising edge.
- `rst_n`: in, 1 bit. Reset is synchronous and active-low.
- `en`: in, 1 bit. Operands on `inp1`/`inp2` are valid this cycle and must be checked `num_regs` cycles later.
- `inp1`: in, `inp_data_width` bits. Operand A, same signal that drives the adder.
- `inp2`: in, `inp_data_width` bits. Operand B.
- `outp`: in, `inp_data_width+1` bits. Adder result.
- `chk_valid`: out, 1 bit. A comparison occurs this cycle.
- `mismatch`: out, 1 bit. One-cycle pulse, high with `chk_valid` when `outp` differs from the expected sum.
- `fail`: out, 1 bit. Sticky; set by the first mismatch.
- `check_count`: out, `cnt_width` bits. Number of comparisons performed, saturating.
- `err_count`: out, `cnt_width` bits. Number of mismatches, saturating.
- `first_exp`: out, `inp_data_width+1` bits. Expected value of the first mismatch.
- `first_got`: out, `inp_data_width+1` bits. Observed `outp` of the first mismatch.
- `first_idx`: out, `cnt_width` bits. Value of `check_count` before the first failing check, i.e. its 0-based index.

## Operation
- Expected sum: `{1'b0,inp1} + {1'b0,inp2}`, computed at full width with no truncation. Example: 255+255 gives 510.
- The delay line has `num_regs` stages and carries the pair (expected, valid), with valid = `en` at capture. Stage k loads from stage k-1 every cycle, with no stall.
- `chk_valid` is the valid bit of the last stage. A comparison at cycle t uses the operands captured at cycle t-`num_regs` against `outp` sampled at cycle t.
- FSM (enum in package), states IDLE, RUN, FAIL:
  - IDLE → RUN on the first cycle with `en`=1.
  - RUN → FAIL on the first `mismatch`.
  - FAIL is absorbing until reset; checking and counting continue.
  - No transition back to IDLE.
- `first_*` registers load only on the RUN→FAIL transition and hold afterwards.
- Counters saturate at all-ones and never wrap. `err_count` ≤ `check_count` always.
- Output registers are direct, with no combinational path from inputs to outputs other than through the delay line.

## Timing
- Reset (`rst_n`=0 at a rising edge) applies the following values at that edge:
  - All valid bits in the delay line are cleared; expected data is don't-care.
  - FSM goes to IDLE.
  - `chk_valid`, `mismatch` and `fail` are 0.
  - Counters are 0.
  - `first_exp`, `first_got` and `first_idx` are 0.
- Reset mid-stream discards in-flight operands. No check occurs until `num_regs` cycles after the first `en`=1 following reset release.
- `mismatch`, `chk_valid` and the counters are registered. They are visible one cycle after the compare edge, so the output is observed `num_regs`+1 cycles after operand capture.
- Gaps in `en` produce matching gaps in `chk_valid`, and `outp` is ignored in those cycles.
- Counter at saturation with a simultaneous mismatch: `err_count` holds, and `mismatch` and `fail` still assert.
- A mismatch on the very first check: `first_idx` = 0.

## Structure
- Package `pipelined_adder_pkg` holds:
  - the state enum (`CHK_IDLE`, `CHK_RUN`, `CHK_FAIL`);
  - localparams for the default widths;
  - a function computing the expected sum width.
- Sub-module `adder_expect_delay`: a parameterised shift register of {valid, data} with width and depth parameters and synchronous active-low clear of the valid bits only. It is reusable for other pipelined units.
- Top level contains the FSM, comparator, counters and first-error capture.

## Test plan
- **Clean stream.** Drive the real adder, `num_regs`=4, `en`=1 for 50 cycles with random operands.
  - Required: `check_count`=46 at cycle 50, `err_count`=0, `fail`=0.
- **Corner sum.** `inp1`=255, `inp2`=255, `en`=1 for one cycle, with `outp` forced to 510 four cycles later.
  - Required: `chk_valid` pulse and no `mismatch`.
  - Repeat with `outp` forced to 254: `mismatch`=1, `fail`=1, `first_exp`=510, `first_got`=254, `first_idx`=0.
- **Gapped enable.** `en` pattern 1,0,1,1,0.
  - Required: `chk_valid` reproduces the same pattern shifted by `num_regs`, and `check_count`=3.
- **Reset mid-stream.** Stream 10 operands, assert `rst_n`=0 for one cycle on cycle 6, then resume.
  - Required: all counters 0 after reset, and no `chk_valid` for 4 cycles after the first post-reset `en`.
- **Saturation.** `cnt_width`=4, 20 checks with every `outp` corrupted.
  - Required: `check_count`=15, `err_count`=15, `first_idx`=0, and `mismatch` still pulses on checks 16–20.
